// File: rtl/pps_timebase.sv
// Local second/fraction timebase disciplined to one of NCH external PPS inputs.
// Optional feature macro: PPS_HOLDOVER_EN (HOLDOVER state; without it a lost reference falls to FREE).
module pps_timebase #(
  parameter int NCH       = 2,
  parameter int CLK_HZ    = 125000000,
  parameter int TOL       = 16,
  parameter int PULSE_CYC = 12500000,
  parameter int LOCK_CNT  = 2,
  parameter int HOLD_MAX  = 4,
  localparam int CW = $clog2(CLK_HZ),
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NCH-1:0]  pps_in,
  input  logic [SW-1:0]   pps_sel,
  output logic            pps_out,
  output logic            pps_edge,
  output logic [CW-1:0]   frac,
  output logic [31:0]     sec,
  output logic [1:0]      state,
  output logic [2:0]      led
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [CW-1:0] FRAC_MAX  = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] GOOD_HI   = CW'(CLK_HZ - TOL);
  localparam logic [CW-1:0] GOOD_LO   = CW'(TOL);
  localparam logic [CW-1:0] EVAL_AT   = CW'(TOL + 1);
  localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYC - 1);

  localparam int GW = $clog2(LOCK_CNT + 2);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);

  logic [NCH-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic           ext_edge_reg;
  logic [SW-1:0]  sel_reg, sel_eff;
  logic           seen_reg;
  logic [CW-1:0]  frac_reg;
  logic [31:0]    sec_reg;
  logic           pps_out_reg, pps_edge_reg;
  logic [1:0]     state_reg, state_next;
  logic [GW-1:0]  goodcnt_reg, goodcnt_next, goodcnt_inc;
  logic [2:0]     led_reg, led_next;
  logic           wrap, sel_change, good, eval, missed, align, boundary, edge_sel;

`ifdef PPS_HOLDOVER_EN
  localparam int HW = $clog2(HOLD_MAX + 2);
  localparam logic [HW-1:0] HOLD_TGT = HW'(HOLD_MAX);
  logic [HW-1:0]  holdcnt_reg, holdcnt_next, holdcnt_inc;
`endif

  // Out-of-range selects fall back to channel 0.
  assign sel_eff  = (int'(pps_sel) < NCH) ? pps_sel : '0;
  assign edge_sel = sync2_reg[sel_eff] & ~sync3_reg[sel_eff];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      sync3_reg    <= '0;
      ext_edge_reg <= 1'b0;
      sel_reg      <= '0;
    end else begin
      sync1_reg    <= pps_in;
      sync2_reg    <= sync1_reg;
      sync3_reg    <= sync2_reg;
      ext_edge_reg <= edge_sel;
      sel_reg      <= pps_sel;
    end
  end

  assign wrap        = (frac_reg == FRAC_MAX);
  assign sel_change  = (pps_sel != sel_reg);
  assign good        = (frac_reg >= GOOD_HI) || (frac_reg <= GOOD_LO);
  assign eval        = (frac_reg == EVAL_AT);
  assign missed      = eval && !seen_reg && !ext_edge_reg;
  // Every accepted external edge re-phases the local second; a select change never does.
  assign align       = ext_edge_reg && !sel_change;
  assign boundary    = wrap || align;
  assign goodcnt_inc = goodcnt_reg + GW'(1);
`ifdef PPS_HOLDOVER_EN
  assign holdcnt_inc = holdcnt_reg + HW'(1);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frac_reg     <= '0;
      sec_reg      <= '0;
      pps_edge_reg <= 1'b0;
      pps_out_reg  <= 1'b0;
      seen_reg     <= 1'b0;
    end else begin
      frac_reg     <= boundary ? '0 : frac_reg + CW'(1);
      sec_reg      <= boundary ? sec_reg + 32'd1 : sec_reg;
      pps_edge_reg <= boundary;
      if (boundary)                    pps_out_reg <= 1'b1;
      else if (frac_reg == PULSE_END)  pps_out_reg <= 1'b0;
      // An edge landing on the evaluation cycle is carried to the next evaluation.
      if (ext_edge_reg)  seen_reg <= 1'b1;
      else if (eval)     seen_reg <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= ST_FREE;
      goodcnt_reg <= '0;
`ifdef PPS_HOLDOVER_EN
      holdcnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      goodcnt_reg <= goodcnt_next;
`ifdef PPS_HOLDOVER_EN
      holdcnt_reg <= holdcnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    goodcnt_next = goodcnt_reg;
`ifdef PPS_HOLDOVER_EN
    holdcnt_next = holdcnt_reg;
`endif
    if (sel_change) begin
      state_next   = ST_FREE;
      goodcnt_next = '0;
`ifdef PPS_HOLDOVER_EN
      holdcnt_next = '0;
`endif
    end else begin
      case (state_reg)
        ST_FREE: begin
          if (ext_edge_reg) begin
            state_next   = ST_ACQ;
            goodcnt_next = '0;
          end
        end
        ST_ACQ: begin
          if (ext_edge_reg) begin
            if (good) begin
              goodcnt_next = goodcnt_inc;
              if (goodcnt_inc >= LOCK_TGT) state_next = ST_LOCK;
            end else begin
              goodcnt_next = '0;
            end
          end else if (missed) begin
            state_next   = ST_FREE;
            goodcnt_next = '0;
          end
        end
        ST_LOCK: begin
          if (ext_edge_reg) begin
            if (!good) begin
              state_next   = ST_ACQ;
              goodcnt_next = '0;
            end
          end else if (missed) begin
`ifdef PPS_HOLDOVER_EN
            state_next   = ST_HOLD;
            holdcnt_next = '0;
`else
            state_next   = ST_FREE;
`endif
          end
        end
        ST_HOLD: begin
`ifdef PPS_HOLDOVER_EN
          if (ext_edge_reg) begin
            if (good) begin
              state_next   = ST_LOCK;
            end else begin
              state_next   = ST_ACQ;
              goodcnt_next = '0;
            end
          end else if (boundary) begin
            holdcnt_next = holdcnt_inc;
            if (holdcnt_inc >= HOLD_TGT) state_next = ST_FREE;
          end
`else
          state_next = ST_FREE;
`endif
        end
      endcase
    end
  end

  always_comb begin
    led_next    = 3'b000;
    led_next[0] = pps_out_reg;
    led_next[1] = (state_reg == ST_LOCK);
`ifdef PPS_HOLDOVER_EN
    led_next[2] = (state_reg == ST_HOLD);
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) led_reg <= 3'b000;
    else        led_reg <= led_next;
  end

  assign pps_out  = pps_out_reg;
  assign pps_edge = pps_edge_reg;
  assign frac     = frac_reg;
  assign sec      = sec_reg;
  assign state    = state_reg;
  assign led      = led_reg;

endmodule

// File: tb/tb_pps_timebase.sv
// Directed bench for pps_timebase: free run, lock-up, phase tolerance, loss of reference,
// select change and asynchronous reset, with a small CLK_HZ so seconds are short.
module tb_pps_timebase;
  localparam int NCH = 2, CLK_HZ = 1000, TOL = 4, PULSE_CYC = 100, LOCK_CNT = 2, HOLD_MAX = 3;
`ifdef PPS_HOLDOVER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  pps_in;
  logic [0:0]  pps_sel;
  logic        pps_out, pps_edge;
  logic [9:0]  frac;
  logic [31:0] sec;
  logic [1:0]  state;
  logic [2:0]  led;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ch;
    int         w;
    logic [1:0] exp_state;
    int         exp_sec;
    logic       exp_led1;
  } rec_t;
  rec_t recs[11];

  pps_timebase #(
    .NCH(NCH), .CLK_HZ(CLK_HZ), .TOL(TOL), .PULSE_CYC(PULSE_CYC),
    .LOCK_CNT(LOCK_CNT), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .pps_in(pps_in), .pps_sel(pps_sel),
    .pps_out(pps_out), .pps_edge(pps_edge), .frac(frac), .sec(sec),
    .state(state), .led(led)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait, pulse the chosen pin for two cycles, then check the realignment the cycle
  // after ext_edge and that the pps_edge strobe lasts one cycle.
  task automatic apply_rec(input int i);
    step(recs[i].w);
    pps_in[recs[i].ch] = 1'b1;
    step(2);
    pps_in = '0;
    step(2);
    chk("rec_frac0",    longint'(frac),     0);
    chk("rec_pps_edge", longint'(pps_edge), 1);
    chk("rec_state",    longint'(state),    longint'(recs[i].exp_state));
    chk("rec_sec",      longint'(sec),      longint'(recs[i].exp_sec));
    chk("rec_led1",     longint'(led[1]),   longint'(recs[i].exp_led1));
    $display("rec %0d ch=%0d state=%0d sec=%0d frac=%0d", i, recs[i].ch, state, sec, frac);
    step(1);
    chk("rec_frac1",      longint'(frac),     1);
    chk("rec_edge_once",  longint'(pps_edge), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] hs;
    hs = HOLD_EN ? 2'd3 : 2'd0;

    recs[0]  = '{0,  300, 2'd1,  3, 1'b0};
    recs[1]  = '{0,  995, 2'd1,  4, 1'b0};
    recs[2]  = '{0,  995, 2'd2,  5, 1'b0};
    recs[3]  = '{0,  995, 2'd2,  6, 1'b1};
    recs[4]  = '{0,  998, 2'd2,  8, 1'b1};
    recs[5]  = '{0, 1005, 2'd1, 10, 1'b0};
    recs[6]  = '{0,  995, 2'd1, 11, 1'b0};
    recs[7]  = '{0,  995, 2'd2, 12, 1'b0};
    recs[8]  = '{1,  299, 2'd1, 17, 1'b0};
    recs[9]  = '{1,  995, 2'd1, 18, 1'b0};
    recs[10] = '{1,  995, 2'd2, 19, 1'b0};

    RST_N   = 1'b0;
    pps_in  = '0;
    pps_sel = '0;
    step(3);
    chk("rst_frac",  longint'(frac),     0);
    chk("rst_sec",   longint'(sec),      0);
    chk("rst_state", longint'(state),    0);
    chk("rst_led",   longint'(led),      0);
    chk("rst_out",   longint'(pps_out),  0);
    chk("rst_edge",  longint'(pps_edge), 0);
    RST_N = 1'b1;

    // Free run from reset.
    step(999);
    chk("free_frac999", longint'(frac),     999);
    chk("free_sec0",    longint'(sec),      0);
    chk("free_noedge",  longint'(pps_edge), 0);
    step(1);
    chk("free_wrap_frac", longint'(frac),     0);
    chk("free_wrap_sec",  longint'(sec),      1);
    chk("free_wrap_edge", longint'(pps_edge), 1);
    chk("free_wrap_out",  longint'(pps_out),  1);
    chk("free_state",     longint'(state),    0);
    step(99);
    chk("pulse_last_hi", longint'(pps_out),  1);
    chk("pulse_edge_lo", longint'(pps_edge), 0);
    step(1);
    chk("pulse_end",     longint'(pps_out), 0);
    chk("led0_lag_hi",   longint'(led[0]),  1);
    step(1);
    chk("led0_lag_lo",   longint'(led[0]),  0);
    step(898);
    chk("free_frac999b", longint'(frac), 999);
    step(1);
    chk("free_sec2",  longint'(sec),      2);
    chk("free_edge2", longint'(pps_edge), 1);
    $display("free run done sec=%0d", sec);

    // Acquire and lock on ch0, phase tolerance, bad edge, relock.
    for (int i = 0; i < 8; i++) apply_rec(i);

    // Reference lost while LOCKED.
    step(999);
    chk("loss_sec13",   longint'(sec),   13);
    chk("loss_state2",  longint'(state), 2);
    step(5);
    chk("loss_frac5",   longint'(frac),  5);
    chk("loss_pre",     longint'(state), 2);
    step(1);
    chk("loss_state",   longint'(state), longint'(hs));
    step(1);
    chk("loss_led2",    longint'(led[2]), longint'(HOLD_EN));
    step(993);
    chk("hold_b1_sec",   longint'(sec),   14);
    chk("hold_b1_state", longint'(state), longint'(hs));
    step(1000);
    chk("hold_b2_sec",   longint'(sec),   15);
    chk("hold_b2_state", longint'(state), longint'(hs));
    step(999);
    chk("hold_b3_pre",   longint'(state), longint'(hs));
    step(1);
    chk("hold_b3_sec",   longint'(sec),   16);
    chk("hold_expired",  longint'(state), 0);
    $display("loss of reference done state=%0d sec=%0d", state, sec);

    // Switch to ch1 and lock on it.
    pps_sel = 1'b1;
    step(1);
    chk("sel1_state", longint'(state), 0);
    chk("sel1_frac",  longint'(frac),  1);
    for (int i = 8; i < 11; i++) apply_rec(i);

    // Select change while LOCKED: FREE next cycle, phase untouched.
    pps_sel = 1'b0;
    step(1);
    chk("selchg_state", longint'(state),  0);
    chk("selchg_frac",  longint'(frac),   2);
    chk("selchg_sec",   longint'(sec),    19);
    chk("selchg_led1",  longint'(led[1]), 1);
    step(1);
    chk("selchg_led1b", longint'(led[1]), 0);
    step(47);
    chk("mid_pulse_out", longint'(pps_out), 1);
    chk("mid_pulse_led", longint'(led[0]),  1);
    $display("select change done state=%0d frac=%0d", state, frac);

    // Asynchronous reset mid-pulse, checked before any clock edge.
    RST_N = 1'b0;
    #1;
    chk("arst_frac",  longint'(frac),     0);
    chk("arst_sec",   longint'(sec),      0);
    chk("arst_state", longint'(state),    0);
    chk("arst_led",   longint'(led),      0);
    chk("arst_out",   longint'(pps_out),  0);
    chk("arst_edge",  longint'(pps_edge), 0);
    step(1);
    RST_N = 1'b1;
    step(10);
    chk("post_rst_frac",  longint'(frac),  10);
    chk("post_rst_sec",   longint'(sec),   0);
    chk("post_rst_state", longint'(state), 0);
    $display("async reset done frac=%0d", frac);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
